// File: rtl/rv_operand_stage.sv
// rv_operand_stage: decode + register read ahead of the ALU.
// Ports: clk, rst (async, active-high); ins/ins_valid/ins_ready (instruction
// handshake); wb_en/wb_rd/wb_data (register-file write port);
// a/b/op/rd/illegal/out_valid/ex_ready (registered issue handshake).
// Define OPSTAGE_BYPASS_EN to forward same-edge write data to the operands.
module rv_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins,
  input  logic            ins_valid,
  output logic            ins_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      op,
  output logic [4:0]      rd,
  output logic            illegal,
  output logic            out_valid,
  input  logic            ex_ready
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [XLEN-1:0] rf_q [32];

  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            ill_q, ill_d;
  logic            vld_q, vld_d;

  logic            accept;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s;
  logic [2:0]      alu_op;
  logic            f3_ok;
  logic            is_r, is_i, is_ld, is_st, is_br;

  assign ins_ready = !vld_q || ex_ready;
  assign accept    = ins_valid && ins_ready;

  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};

  assign is_r  = (opc == 7'b0110011);
  assign is_i  = (opc == 7'b0010011);
  assign is_ld = (opc == 7'b0000011);
  assign is_st = (opc == 7'b0100011);
  assign is_br = (opc == 7'b1100011);

  // x0 reads zero regardless of array contents.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef OPSTAGE_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1)
      rs1_val = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2)
      rs2_val = wb_data;
`endif
  end

  always_comb begin
    alu_op = OP_AND;
    f3_ok  = 1'b1;
    unique case (f3)
      3'b000:  alu_op = OP_ADD;
      3'b111:  alu_op = OP_AND;
      3'b110:  alu_op = OP_OR;
      3'b010:  alu_op = OP_SLT;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    op_d  = OP_AND;
    rd_d  = 5'd0;
    ill_d = 1'b0;
    unique case (1'b1)
      is_r && f3_ok: begin
        a_d  = rs1_val;
        b_d  = rs2_val;
        op_d = (f3 == 3'b000 && ins[30]) ? OP_SUB : alu_op;
        rd_d = ins[11:7];
      end
      is_i && f3_ok: begin
        a_d  = rs1_val;
        b_d  = imm_i;
        op_d = alu_op;
        rd_d = ins[11:7];
      end
      is_ld: begin
        a_d  = rs1_val;
        b_d  = imm_i;
        op_d = OP_ADD;
        rd_d = ins[11:7];
      end
      is_st: begin
        a_d  = rs1_val;
        b_d  = imm_s;
        op_d = OP_ADD;
      end
      is_br: begin
        a_d  = rs1_val;
        b_d  = rs2_val;
        op_d = OP_SUB;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    if (accept)
      vld_d = 1'b1;
    else if (ex_ready)
      vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++)
        rf_q[k] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_AND;
      rd_q  <= 5'd0;
      ill_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (accept) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        rd_q  <= rd_d;
        ill_q <= ill_d;
      end
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign rd        = rd_q;
  assign illegal   = ill_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rv_operand_stage.sv
// tb_rv_operand_stage: directed + randomized checks of rv_operand_stage
// against a behavioural model of the decode rules and register file.
module tb_rv_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic        illegal;
  logic        out_valid;
  logic        ex_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_ill;
  logic [31:0] held_a;

  always #5 clk = ~clk;

  rv_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .a(a), .b(b), .op(op), .rd(rd), .illegal(illegal),
    .out_valid(out_valid), .ex_ready(ex_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    int s;
    s = int'(v);
    if (s >= 2048) s = s - 4096;
    return 32'(s);
  endfunction

  // Expected issue bundle from the instruction rules.
  task automatic mdec(input logic [31:0] i, input logic [31:0] r1,
                      input logic [31:0] r2,
                      output logic [31:0] ea, output logic [31:0] eb,
                      output logic [2:0] eop, output logic [4:0] erd,
                      output logic eill);
    logic [6:0] opc;
    logic [2:0] f3;
    int         ok;
    logic [2:0] fop;
    opc = i[6:0];
    f3  = i[14:12];
    ok  = 1;
    fop = 3'b000;
    if (f3 == 3'b000) fop = 3'b010;
    else if (f3 == 3'b111) fop = 3'b000;
    else if (f3 == 3'b110) fop = 3'b001;
    else if (f3 == 3'b010) fop = 3'b111;
    else ok = 0;
    ea = 0; eb = 0; eop = 3'b000; erd = 0; eill = 0;
    if (opc == 7'h33 && ok == 1) begin
      ea = r1; eb = r2; erd = i[11:7];
      eop = (f3 == 3'b000 && i[30]) ? 3'b110 : fop;
    end else if (opc == 7'h13 && ok == 1) begin
      ea = r1; eb = sx12(i[31:20]); erd = i[11:7]; eop = fop;
    end else if (opc == 7'h03) begin
      ea = r1; eb = sx12(i[31:20]); erd = i[11:7]; eop = 3'b010;
    end else if (opc == 7'h23) begin
      ea = r1; eb = sx12({i[31:25], i[11:7]}); eop = 3'b010;
    end else if (opc == 7'h63) begin
      ea = r1; eb = r2; eop = 3'b110;
    end else begin
      eill = 1;
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r,
                                        input logic we,
                                        input logic [4:0] wr,
                                        input logic [31:0] wd);
    if (r == 0) return 0;
`ifdef OPSTAGE_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return m_rf[r];
  endfunction

  task automatic mreset();
    for (int k = 0; k < 32; k++) m_rf[k] = 0;
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_ill = 0;
  endtask

  task automatic check_out(input string tg);
    chk({tg, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tg, ".a"}, a, m_a);
      chk({tg, ".b"}, b, m_b);
      chk({tg, ".op"}, 32'(op), 32'(m_op));
      chk({tg, ".rd"}, 32'(rd), 32'(m_rd));
      chk({tg, ".ill"}, 32'(illegal), 32'(m_ill));
    end
  endtask

  // Called just after a falling edge: drive, run the model, clock, check.
  task automatic step(input string tg, input logic v, input logic [31:0] i,
                      input logic er, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd);
    logic [31:0] r1, r2;
    ins_valid = v; ins = i; ex_ready = er;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    chk({tg, ".rdy"}, 32'(ins_ready), 32'(!m_valid || er));
    if (v && (!m_valid || er)) begin
      r1 = mread(i[19:15], we, wr, wd);
      r2 = mread(i[24:20], we, wr, wd);
      mdec(i, r1, r2, m_a, m_b, m_op, m_rd, m_ill);
      m_valid = 1;
    end else if (er) begin
      m_valid = 0;
    end
    if (we && wr != 0) m_rf[wr] = wd;
    @(posedge clk);
    @(negedge clk);
    check_out(tg);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  r1, r2, d;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [11:0] imm;
    logic [2:0]  f3set [5];
    f3set = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b000};
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    d   = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    f3  = f3set[$urandom_range(0, 4)];
    case ($urandom_range(0, 7))
      0: return {1'b0, 1'($urandom), 5'b0, r2, r1, f3, d, 7'h33};
      1: return {imm, r1, f3, d, 7'h13};
      2: return {imm, r1, 3'b010, d, 7'h03};
      3: return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'h23};
      4: return {7'b0, r2, r1, 3'b000, d, 7'h63};
      5: return {7'b0, r2, r1, 3'b001, d, 7'h33};
      6: return {imm, r1, 3'b101, d, 7'h13};
      default: begin
        opc = 7'($urandom);
        if (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 ||
            opc == 7'h23 || opc == 7'h63)
          opc = 7'h7F;
        return {imm, r1, f3, d, opc};
      end
    endcase
  endfunction

  initial begin
    rst = 1; ins = 0; ins_valid = 0; ex_ready = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    mreset();
    #3;
    check_out("rst0");
    chk("rst0.a", a, 0);
    chk("rst0.ill", 32'(illegal), 0);
    @(negedge clk);
    rst = 0;

    step("wr1", 0, 0, 1, 1, 5'd1, 32'd7);
    step("wr2", 0, 0, 1, 1, 5'd2, 32'd3);

    step("sub", 1, 32'h402081B3, 1, 0, 0, 0);
    chk("sub.a_c", a, 32'd7);
    chk("sub.b_c", b, 32'd3);
    chk("sub.op_c", 32'(op), 32'b110);
    chk("sub.rd_c", 32'(rd), 32'd3);

    step("addi", 1, 32'hFFF08213, 1, 0, 0, 0);
    chk("addi.b_c", b, 32'hFFFFFFFF);
    chk("addi.op_c", 32'(op), 32'b010);

    step("sw", 1, 32'hFE20AE23, 1, 0, 0, 0);
    chk("sw.b_c", b, 32'hFFFFFFFC);
    chk("sw.rd_c", 32'(rd), 0);

    step("bp0", 1, 32'h402081B3, 1, 0, 0, 0);
    held_a = a;
    for (int k = 0; k < 3; k++) begin
      step("bp", 1, 32'hFFF08213, 0, 0, 0, 0);
      chk("bp.hold_a", a, held_a);
      chk("bp.hold_op", 32'(op), 32'b110);
    end
    step("bp_rel", 1, 32'hFFF08213, 1, 0, 0, 0);
    chk("bp_rel.b_c", b, 32'hFFFFFFFF);

    step("byp", 1, 32'h000081B3, 1, 1, 5'd1, 32'h55);
`ifdef OPSTAGE_BYPASS_EN
    chk("byp.a_c", a, 32'h55);
`else
    chk("byp.a_c", a, 32'd7);
`endif
    step("wx0", 0, 0, 1, 1, 5'd0, 32'hDEAD);
    step("rx0", 1, 32'h000001B3, 1, 0, 0, 0);
    chk("rx0.a_c", a, 0);

    step("ill", 1, 32'h0000007F, 1, 0, 0, 0);
    chk("ill.ill_c", 32'(illegal), 1);
    chk("ill.v_c", 32'(out_valid), 1);

    step("wr5", 0, 0, 1, 1, 5'd5, 32'h1234);
    step("pend", 1, 32'h000281B3, 0, 0, 0, 0);
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hBEEF; ins_valid = 0;
    #2 rst = 1;
    #1;
    mreset();
    check_out("mrst");
    chk("mrst.a", a, 0);
    chk("mrst.b", b, 0);
    chk("mrst.op", 32'(op), 0);
    chk("mrst.rd", 32'(rd), 0);
    chk("mrst.ill", 32'(illegal), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    step("rx5", 1, 32'h000281B3, 1, 0, 0, 0);
    chk("rx5.a_c", a, 0);

    for (int n = 0; n < 400; n++)
      step("rnd", 1'($urandom_range(0, 3) != 0), rand_ins(),
           1'($urandom_range(0, 2) != 0), 1'($urandom),
           5'($urandom_range(0, 7)), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
